// File: rtl/md_unit.sv
// md_unit: multiply/divide controller for the pipelined MIPS core.
// It holds the architectural HI/LO registers and accepts mult/multu/div/divu/
// mthi/mtlo from the E stage. Each mul/div runs a fixed-latency busy window,
// and the result is committed to HI/LO when that window ends. While the unit
// is busy, or a mul/div is starting, it requests a stall for any HI/LO
// instruction waiting in D.
// Optional feature: define MD_DIV_EN to compile in div/divu. When MD_DIV_EN
// is undefined, ops 3/4 behave as "none" and no divider is built.
module md_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  md_op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        id_md,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic        busy,
  output logic        md_stall
);

  localparam int DATA_W  = 32;
  localparam int MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic [DATA_W-1:0] p_hi;
  logic [DATA_W-1:0] p_lo;
  logic              p_wr;

  logic              is_mul;
  logic              is_div;
  logic              start_mul_div;

  logic signed [2*DATA_W-1:0] prod_s;
  logic        [2*DATA_W-1:0] prod_u;

  logic [DATA_W-1:0] res_hi;
  logic [DATA_W-1:0] res_lo;
  logic              res_wr;

  assign is_mul = (md_op == 3'd1) || (md_op == 3'd2);
`ifdef MD_DIV_EN
  assign is_div = (md_op == 3'd3) || (md_op == 3'd4);
`else
  assign is_div = 1'b0;
`endif
  assign start_mul_div = start & (is_mul | is_div);

  assign md_stall = id_md & (busy | start_mul_div);

  // Full-width products from sign- or zero-extended operands.
  assign prod_s = $signed({{DATA_W{A[DATA_W-1]}}, A}) * $signed({{DATA_W{B[DATA_W-1]}}, B});
  assign prod_u = {{DATA_W{1'b0}}, A} * {{DATA_W{1'b0}}, B};

`ifdef MD_DIV_EN
  logic signed [DATA_W-1:0] a_s;
  logic signed [DATA_W-1:0] b_s;
  logic signed [DATA_W-1:0] q_s;
  logic signed [DATA_W-1:0] r_s;
  logic        [DATA_W-1:0] q_u;
  logic        [DATA_W-1:0] r_u;
  logic                     div_ovf;

  assign a_s = $signed(A);
  assign b_s = $signed(B);
  assign q_s = a_s / b_s;
  assign r_s = a_s % b_s;
  assign q_u = A / B;
  assign r_u = A % B;
  // The most negative value divided by -1 overflows; the answer is defined explicitly.
  assign div_ovf = (A == {1'b1, {(DATA_W-1){1'b0}}}) && (B == {DATA_W{1'b1}});
`endif

  // Select the pending result for the op in E; res_wr clears on a zero divisor so HI/LO hold.
  always_comb begin
    res_hi = '0;
    res_lo = '0;
    res_wr = 1'b0;
    case (md_op)
      3'd1: begin
        {res_hi, res_lo} = prod_s;
        res_wr = 1'b1;
      end
      3'd2: begin
        {res_hi, res_lo} = prod_u;
        res_wr = 1'b1;
      end
`ifdef MD_DIV_EN
      3'd3: begin
        if (B != '0) begin
          res_wr = 1'b1;
          if (div_ovf) begin
            res_lo = {1'b1, {(DATA_W-1){1'b0}}};
            res_hi = '0;
          end else begin
            res_lo = q_s;
            res_hi = r_s;
          end
        end
      end
      3'd4: begin
        if (B != '0) begin
          res_wr = 1'b1;
          res_lo = q_u;
          res_hi = r_u;
        end
      end
`endif
      default: ;
    endcase
  end

  // Control FSM: IDLE accepts ops, and RUN counts down the busy window and commits on the last cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
      busy  <= 1'b0;
      HI    <= '0;
      LO    <= '0;
      p_hi  <= '0;
      p_lo  <= '0;
      p_wr  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start_mul_div) begin
            p_hi  <= res_hi;
            p_lo  <= res_lo;
            p_wr  <= res_wr;
            busy  <= 1'b1;
            state <= RUN;
`ifdef MD_DIV_EN
            cnt   <= is_div ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
`else
            cnt   <= CNT_W'(MULT_CYCLES);
`endif
          end else if (start && (md_op == 3'd5)) begin
            HI <= A;
          end else if (start && (md_op == 3'd6)) begin
            LO <= A;
          end
        end
        RUN: begin
          cnt <= cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) begin
            busy  <= 1'b0;
            state <= IDLE;
            if (p_wr) begin
              HI <= p_hi;
              LO <= p_lo;
            end
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_md_unit.sv
// tb_md_unit: scoreboard bench for md_unit. Expected {HI,LO} values are
// queued when an op is driven and compared once the unit has finished.
module tb_md_unit;

  localparam int MULT_N = 5;
  localparam int DIV_N  = 10;
`ifdef MD_DIV_EN
  localparam bit DIV_ON = 1'b1;
`else
  localparam bit DIV_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [2:0]  md_op = 3'd0;
  logic [31:0] A = '0;
  logic [31:0] B = '0;
  logic        id_md = 1'b0;
  logic [31:0] HI;
  logic [31:0] LO;
  logic        busy;
  logic        md_stall;

  int          n_vec = 0;
  int          n_err = 0;
  logic [63:0] sb[$];
  logic [63:0] hl_m = '0;

  md_unit #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
    .clk(clk), .reset(reset), .start(start), .md_op(md_op), .A(A), .B(B),
    .id_md(id_md), .HI(HI), .LO(LO), .busy(busy), .md_stall(md_stall)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Reference model, written with sign/magnitude arithmetic.
  function automatic logic [63:0] model(input logic [2:0] op, input logic [31:0] a,
                                        input logic [31:0] b, input logic [63:0] prev);
    longint      ps;
    logic [31:0] ma, mb, q, r;
    case (op)
      3'd1: begin
        ps = longint'($signed(a)) * longint'($signed(b));
        return ps;
      end
      3'd2: return {32'd0, a} * {32'd0, b};
      3'd3: begin
        if (!DIV_ON || b == 0) return prev;
        ma = a[31] ? -a : a;
        mb = b[31] ? -b : b;
        q  = ma / mb;
        r  = ma % mb;
        if (a[31] ^ b[31]) q = -q;
        if (a[31]) r = -r;
        return {r, q};
      end
      3'd4: begin
        if (!DIV_ON || b == 0) return prev;
        return {a % b, a / b};
      end
      default: return prev;
    endcase
  endfunction

  function automatic int busy_len(input logic [2:0] op);
    if (op == 3'd1 || op == 3'd2) return MULT_N;
    if ((op == 3'd3 || op == 3'd4) && DIV_ON) return DIV_N;
    return 0;
  endfunction

  // Drive one op with id_md held high, and check the stall, the busy window and the committed result.
  task automatic run_md(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    int          n;
    int          n_exp;
    logic [63:0] prev;
    prev  = hl_m;
    n_exp = busy_len(op);
    hl_m  = model(op, a, b, prev);
    sb.push_back(hl_m);
    start = 1'b1; md_op = op; A = a; B = b; id_md = 1'b1;
    #1;
    chk("stall_T", 64'(md_stall), 64'(n_exp > 0));
    tick();
    start = 1'b0; md_op = 3'd0; A = $urandom; B = $urandom;
    n = 0;
    while (busy && n < 200) begin
      chk("stall_busy", 64'(md_stall), 64'd1);
      chk("hilo_hold", {HI, LO}, prev);
      tick();
      n++;
    end
    chk("busy_cycles", 64'(n), 64'(n_exp));
    chk("stall_after", 64'(md_stall), 64'd0);
    chk("hilo", {HI, LO}, sb.pop_front());
    id_md = 1'b0;
  endtask

  task automatic run_mt(input logic hi_sel, input logic [31:0] v);
    hl_m = hi_sel ? {v, hl_m[31:0]} : {hl_m[63:32], v};
    sb.push_back(hl_m);
    start = 1'b1; md_op = hi_sel ? 3'd5 : 3'd6; A = v; B = '0;
    tick();
    start = 1'b0; md_op = 3'd0;
    chk("mt_busy", 64'(busy), 64'd0);
    chk("mt_hilo", {HI, LO}, sb.pop_front());
  endtask

  // A start must never reach the unit while it is busy.
  always @(negedge clk)
    if (!reset) chk("start_in_run", 64'(start & busy & (md_op inside {[3'd1:3'd4]})), 64'd0);

  initial begin
    int          n;
    logic [2:0]  op;
    logic [31:0] ra, rb;

    // Reset state
    reset = 1'b1; id_md = 1'b1;
    tick(); tick();
    chk("rst_hilo", {HI, LO}, 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_stall", 64'(md_stall), 64'd0);
    reset = 1'b0; id_md = 1'b0;
    tick();

    run_mt(1'b1, 32'h11);
    run_mt(1'b0, 32'h22);
    run_md(3'd1, 32'hFFFF_FFFF, 32'd2);
    chk("mult_ref", {HI, LO}, 64'hFFFF_FFFF_FFFF_FFFE);
    run_md(3'd2, 32'hFFFF_FFFF, 32'd2);
    chk("multu_ref", {HI, LO}, 64'h0000_0001_FFFF_FFFE);
    run_md(3'd3, 32'hFFFF_FFF9, 32'd2);
    chk("div_ref", {HI, LO}, DIV_ON ? 64'hFFFF_FFFF_FFFF_FFFD : 64'h0000_0001_FFFF_FFFE);
    run_mt(1'b1, 32'h11);
    run_mt(1'b0, 32'h22);
    run_md(3'd4, 32'h1234_5678, 32'd0);
    chk("divu_zero", {HI, LO}, 64'h0000_0011_0000_0022);
    run_md(3'd3, 32'h8000_0000, 32'hFFFF_FFFF);
    run_md(3'd4, 32'hFFFF_FFFF, 32'd7);
    run_md(3'd3, 32'd100, 32'd0);
    run_md(3'd7, 32'd5, 32'd6);
    run_md(3'd0, 32'd5, 32'd6);
    run_md(3'd3, 32'd7, 32'hFFFF_FFFE);

    for (int i = 0; i < 10; i++) begin
      op = 3'($urandom_range(1, 4));
      ra = $urandom;
      rb = (i % 3 == 0) ? 32'($urandom_range(1, 20)) : $urandom;
      run_md(op, ra, rb);
    end

    // Reset during RUN aborts the op and discards the pending result
    run_mt(1'b1, 32'hAB);
    start = 1'b1; md_op = 3'd1; A = 32'd3; B = 32'd4;
    tick();
    start = 1'b0; md_op = 3'd0;
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    hl_m = '0;
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_hilo", {HI, LO}, 64'd0);
    n = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (busy) n++;
    end
    chk("abort_no_busy", 64'(n), 64'd0);
    chk("abort_no_commit", {HI, LO}, 64'd0);

    // Reset and start in the same cycle: reset wins
    run_mt(1'b0, 32'h55);
    reset = 1'b1; start = 1'b1; md_op = 3'd1; A = 32'd9; B = 32'd9; id_md = 1'b1;
    #1;
    chk("rst_start_stall", 64'(md_stall), 64'd1);
    tick();
    reset = 1'b0; start = 1'b0; md_op = 3'd0; id_md = 1'b0;
    hl_m = '0;
    chk("rst_start_busy", 64'(busy), 64'd0);
    chk("rst_start_hilo", {HI, LO}, 64'd0);
    run_md(3'd2, 32'd6, 32'd7);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
